// File: rtl/audio_sample_conditioner.sv
// Interleaved audio sample capture -> per-frame signed shift -> serial TX readout.
// Build option: define AUDIO_COND_SAT_EN to saturate left shifts and drive clip_o.
module audio_sample_conditioner #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int SHIFT_W    = 4
) (
  input  logic                           lmmi_clk_i,
  input  logic                           reset_n_i,
  input  logic                           enable_i,
  input  logic signed [SHIFT_W-1:0]      shift_i,
  input  logic                           rx_valid_i,
  input  logic [31:0]                    rx_data_i,
  output logic                           frame_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]   frame_data_o,
  input  logic                           tx_req_i,
  output logic [31:0]                    tx_data_o,
  output logic                           underrun_o,
  output logic                           overrun_o,
  output logic                           clip_o
);

  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int XW    = DATA_WIDTH + (1 << (SHIFT_W - 1)) + 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

`ifdef AUDIO_COND_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  logic [CNT_W-1:0]      r_rx_cnt;
  logic [CNT_W-1:0]      r_tx_ptr;
  logic [DATA_WIDTH-1:0] r_cap_p0  [NUM_CH];
  logic [DATA_WIDTH-1:0] r_proc_p1 [NUM_CH];
  logic                  r_vld_p1;
  logic                  r_have_frame;
  logic                  r_clip;
  logic [DATA_WIDTH-1:0] w_shift_p1 [NUM_CH];
  logic                  w_clip_ch  [NUM_CH];
  logic                  w_clip_any;
  logic                  w_have_frame;
  logic [DATA_WIDTH-1:0] w_rx_smp;
  logic                  w_rx_unused;

  assign w_rx_smp     = rx_data_i[DATA_WIDTH-1:0];
  assign w_rx_unused  = ^rx_data_i;
  assign w_have_frame = r_have_frame | frame_valid_o;
  assign clip_o       = r_clip;

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [XW-1:0] v,
                                                     output logic clip);
`ifdef AUDIO_COND_SAT_EN
    logic fits;
    fits = (v == XW'(signed'(v[DATA_WIDTH-1:0])));
    clip = 1'b0;
    if (!fits) begin
      clip = 1'b1;
      return v[XW-1] ? SAT_MIN : SAT_MAX;
    end
`else
    clip = 1'b0;
`endif
    return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_sample(input logic [DATA_WIDTH-1:0] smp,
                                                         input logic signed [SHIFT_W-1:0] sh,
                                                         output logic clip);
    logic signed [DATA_WIDTH-1:0] s;
    logic signed [XW-1:0]         ext;
    logic signed [SHIFT_W:0]      neg;
    s    = smp;
    clip = 1'b0;
    if (!sh[SHIFT_W-1]) begin
      shift_sample = s >>> sh;
    end else begin
      // widen before negating so the most negative shift code becomes a positive amount
      neg = -((SHIFT_W+1)'(sh));
      ext = XW'(s) <<< neg;
      shift_sample = saturate(ext, clip);
    end
  endfunction

  function automatic logic [31:0] sext32(input logic [DATA_WIDTH-1:0] v);
    logic signed [DATA_WIDTH-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  // p0 capture / p1 process-stage load on channel wrap
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_cnt <= '0;
      r_vld_p1 <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cap_p0[i]  <= '0;
        r_proc_p1[i] <= '0;
      end
    end else if (!enable_i) begin
      r_rx_cnt <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (rx_valid_i) begin
        r_cap_p0[r_rx_cnt] <= w_rx_smp;
        if (r_rx_cnt == LAST_CH) begin
          r_rx_cnt <= '0;
          r_vld_p1 <= 1'b1;
          for (int i = 0; i < NUM_CH - 1; i++) r_proc_p1[i] <= r_cap_p0[i];
          r_proc_p1[NUM_CH-1] <= w_rx_smp;
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_clip_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clip_ch[i]  = 1'b0;
      w_shift_p1[i] = shift_sample(r_proc_p1[i], shift_i, w_clip_ch[i]);
      w_clip_any    = w_clip_any | w_clip_ch[i];
    end
  end

  // p2 frame output register
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_valid_o <= 1'b0;
      frame_data_o  <= '0;
      r_clip        <= 1'b0;
    end else begin
      frame_valid_o <= enable_i & r_vld_p1;
      if (enable_i && r_vld_p1) begin
        for (int i = 0; i < NUM_CH; i++) frame_data_o[i*DATA_WIDTH +: DATA_WIDTH] <= w_shift_p1[i];
        if (w_clip_any) r_clip <= 1'b1;
      end
    end
  end

  // TX readout reads the registered frame, so a coincident update returns the old frame
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tx_ptr     <= '0;
      tx_data_o    <= '0;
      underrun_o   <= 1'b0;
      overrun_o    <= 1'b0;
      r_have_frame <= 1'b0;
    end else begin
      if (frame_valid_o) r_have_frame <= 1'b1;
      if (!enable_i) begin
        r_tx_ptr <= '0;
      end else begin
        if (r_vld_p1 && (r_tx_ptr != '0)) overrun_o <= 1'b1;
        if (tx_req_i) begin
          if (!w_have_frame) begin
            tx_data_o  <= '0;
            underrun_o <= 1'b1;
          end else begin
            tx_data_o <= sext32(frame_data_o[int'(r_tx_ptr)*DATA_WIDTH +: DATA_WIDTH]);
            r_tx_ptr  <= (r_tx_ptr == LAST_CH) ? '0 : r_tx_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Directed bench for audio_sample_conditioner (DATA_WIDTH=24, NUM_CH=2, SHIFT_W=4).
module tb_audio_sample_conditioner;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic signed [3:0] shift;
  logic              rx_valid;
  logic [31:0]       rx_data;
  logic              frame_valid;
  logic [47:0]       frame_data;
  logic              tx_req;
  logic [31:0]       tx_data;
  logic              underrun, overrun, clip;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_ch0;
  logic        exp_clip;

  audio_sample_conditioner #(.DATA_WIDTH(24), .NUM_CH(2), .SHIFT_W(4)) dut (
    .lmmi_clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .shift_i(shift),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .frame_valid_o(frame_valid), .frame_data_o(frame_data),
    .tx_req_i(tx_req), .tx_data_o(tx_data),
    .underrun_o(underrun), .overrun_o(overrun), .clip_o(clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_sample(input logic [31:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic tx_read(input string tag, input logic [31:0] exp);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk(tag, tx_data, exp);
  endtask

  // leaves the bench in the cycle where frame_valid should be high
  task automatic send_frame(input string tag, input logic [31:0] a, input logic [31:0] b);
    rx_sample(a);
    rx_sample(b);
    tick();
    chk({tag, "_fv"}, frame_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; shift = 4'sd0;
    rx_valid = 1'b0; rx_data = '0; tx_req = 1'b0;
    #23;
    chk("rst_fv",   frame_valid, 1'b0);
    chk("rst_fd",   frame_data,  48'h0);
    chk("rst_tx",   tx_data,     32'h0);
    chk("rst_flags", {underrun, overrun, clip}, 3'b000);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    shift  = 4'sd3;

    // read before any frame
    tx_read("underrun_tx", 32'h0);
    chk("underrun_set", underrun, 1'b1);

    // two-channel frame, arithmetic right shift by 3
    rx_sample(32'h000800);
    rx_sample(32'hFFF800);
    chk("lat_k1_fv", frame_valid, 1'b0);
    tick();
    chk("lat_k2_fv", frame_valid, 1'b1);
    chk("rsh_frame", frame_data, {24'hFFFF00, 24'h000100});
    tick();
    chk("fv_pulse", frame_valid, 1'b0);
    tx_read("rsh_tx0", 32'h00000100);
    tx_read("rsh_tx1", 32'hFFFFFF00);
    chk("underrun_sticky", underrun, 1'b1);

    // overrun only when a frame lands with the TX pointer mid-frame
    shift = 4'sd0;
    send_frame("ovr_a", 32'h1, 32'h2);
    chk("ovr_after_a", overrun, 1'b0);
    send_frame("ovr_b", 32'h3, 32'h4);
    chk("ovr_after_b", overrun, 1'b0);
    tx_read("ovr_read", 32'h3);
    send_frame("ovr_c", 32'h5, 32'h6);
    chk("ovr_after_c", overrun, 1'b1);
    tx_read("ovr_tail", 32'h6);

    // TX read on the same edge as a frame update sees the old frame
    rx_sample(32'h7);
    rx_valid = 1'b1; rx_data = 32'h8;
    tick();
    rx_valid = 1'b0; rx_data = '0;
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk("coinc_fv", frame_valid, 1'b1);
    chk("coinc_frame", frame_data, {24'h000008, 24'h000007});
    chk("coinc_tx_old", tx_data, 32'h5);

    // left shift by 2: 0x300000 overflows 24 bits, 0x10 does not
`ifdef AUDIO_COND_SAT_EN
    exp_ch0 = 24'h7FFFFF; exp_clip = 1'b1;
`else
    exp_ch0 = 24'hC00000; exp_clip = 1'b0;
`endif
    chk("clip_before", clip, 1'b0);
    shift = -4'sd2;
    send_frame("lsh", 32'h300000, 32'h10);
    chk("lsh_frame", frame_data, {24'h000040, exp_ch0});
    chk("lsh_clip", clip, exp_clip);
    chk("ovr_sticky", overrun, 1'b1);

    // enable low discards a partial frame and rewinds the TX pointer
    shift = 4'sd0;
    rx_sample(32'hAA);
    enable = 1'b0;
    rx_valid = 1'b1; rx_data = 32'h55;
    tick();
    rx_valid = 1'b0; rx_data = '0;
    chk("dis_hold_fd", frame_data, {24'h000040, exp_ch0});
    enable = 1'b1;
    send_frame("resync", 32'h10, 32'h20);
    chk("resync_frame", frame_data, {24'h000020, 24'h000010});
    tx_read("resync_tx0", 32'h10);

    // asynchronous reset mid-frame, then a clean frame
    rx_sample(32'h99);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_fd", frame_data, 48'h0);
    chk("arst_tx", tx_data, 32'h0);
    chk("arst_flags", {frame_valid, underrun, overrun, clip}, 4'b0000);
    #7;
    rst_n = 1'b1;
    tick();
    shift = 4'sd1;
    send_frame("post_rst", 32'h40, 32'h80);
    chk("post_rst_frame", frame_data, {24'h000040, 24'h000020});
    tx_read("post_rst_tx0", 32'h20);
    chk("post_rst_underrun", underrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
